// File: rtl/tristate_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tristate_bus_arbiter
//
// Purpose:
//   Sits directly in front of the tristate drivers of a shared bus. It grants
//   the bus to one of N requesters in round-robin order and limits how long an
//   owner may hold it. Between two owners it forces an all-off turnaround gap,
//   so that two drivers can never fight over the bus.
//
// Ports:
//   clk_in     - rising-edge clock
//   rst_n_in   - asynchronous active-low reset
//   req_in     - per-requester level request, sampled on clk_in
//   gnt_out    - one-hot grant back to the requester
//   en_out     - one-hot tristate enable (bit i drives a_in of driver i),
//                always equal to gnt_out
//   owner_out  - index of the current owner, 0 when the bus is idle or turning
//   busy_out   - high while any enable is high
// ----------------------------------------------------------------------------
module tristate_bus_arbiter #(
   parameter int N         = 4,
   parameter int MAX_HOLD  = 8,
   parameter int TA_CYCLES = 1
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic [N-1:0]         req_in,
   output logic [N-1:0]         gnt_out,
   output logic [N-1:0]         en_out,
   output logic [$clog2(N)-1:0] owner_out,
   output logic                 busy_out
);

   localparam int IW = $clog2(N);
   localparam int HW = (MAX_HOLD  > 1) ? $clog2(MAX_HOLD)  : 1;
   localparam int TW = (TA_CYCLES > 1) ? $clog2(TA_CYCLES) : 1;

   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [TW-1:0] TA_LAST   = TW'(TA_CYCLES - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_TURN  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [TW-1:0] ta_q, ta_d;
   logic          busy_q;

   logic [IW-1:0] pickIdx;
   logic [N-1:0]  pickGnt;
   logic [IW:0]   scanIdx;
   logic [IW:0]   ownerInc;
   logic [IW-1:0] ptrAfterOwner;

   // Round-robin search: first set request starting at ptr_q, wrapping
   // modulo N. The sum is one bit wider so the wrap works for any N.
   always_comb begin
      pickIdx = '0;
      scanIdx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         scanIdx = {1'b0, ptr_q} + (IW+1)'(k);
         if (scanIdx >= (IW+1)'(N)) begin
            scanIdx = scanIdx - (IW+1)'(N);
         end
         if (req_in[scanIdx[IW-1:0]]) begin
            pickIdx = scanIdx[IW-1:0];
         end
      end
      pickGnt = N'(1) << pickIdx;
   end

   // After a release the owner drops to lowest priority: the search starts
   // at the requester just after it.
   always_comb begin
      ownerInc = {1'b0, owner_q} + (IW+1)'(1);
      if (ownerInc >= (IW+1)'(N)) begin
         ptrAfterOwner = '0;
      end else begin
         ptrAfterOwner = ownerInc[IW-1:0];
      end
   end

   // Next-state logic. A release always passes through turnaround, even
   // when another request is already waiting, so enables never change
   // directly from one owner to another.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      ta_d    = ta_q;
      case (state_q)
         S_IDLE: begin
            if (|req_in) begin
               state_d = S_GRANT;
               gnt_d   = pickGnt;
               owner_d = pickIdx;
               hold_d  = '0;
            end
         end
         S_GRANT: begin
            if (!req_in[owner_q] || (hold_q == HOLD_LAST)) begin
               state_d = S_TURN;
               gnt_d   = '0;
               owner_d = '0;
               ptr_d   = ptrAfterOwner;
               ta_d    = '0;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         S_TURN: begin
            if (ta_q == TA_LAST) begin
               if (|req_in) begin
                  state_d = S_GRANT;
                  gnt_d   = pickGnt;
                  owner_d = pickIdx;
                  hold_d  = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               ta_d = ta_q + TW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = '0;
            owner_d = '0;
         end
      endcase
   end

   // State registers; reset clears the enables without waiting for a clock.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
         ta_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         ta_q    <= ta_d;
         busy_q  <= |gnt_d;
      end
   end

   assign gnt_out   = gnt_q;
   assign en_out    = gnt_q;
   assign owner_out = owner_q;
   assign busy_out  = busy_q;

endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
- Controller directly upstream of the shared-bus tristate drivers.
- Arbitrates up to N requesters for one tristate bus and produces one-hot enables; each enable drives the a_in of one tristate buffer.
- Guarantees that at most one driver is enabled in any cycle.
- Inserts a programmable all-off turnaround gap between owners so no two drivers ever overlap.
- Round-robin fairness with a maximum hold time per grant.

Parameters:
N, 4, number of requesters/tristate drivers (2..16)
MAX_HOLD, 8, maximum consecutive cycles one owner keeps the bus (>=1)
TA_CYCLES, 1, all-enables-low cycles between two owners (>=1)

Ports:
clk_in  input  1  rising-edge clock
rst_n_in  input  1  reset; asynchronous assert, active-low
req_in  input  N  per-requester bus request, level, sampled on clk_in
gnt_out  output  N  one-hot grant back to the requester
en_out  output  N  one-hot tristate enable, bit i drives a_in of driver i; identical to gnt_out
owner_out  output  clog2(N)  index of current owner; 0 when no owner
busy_out  output  1  OR of en_out

Behaviour:
- Reset (rst_n_in low):
  - gnt_out, en_out, owner_out and busy_out go to 0 immediately, with no clock edge required.
  - State goes to IDLE; hold_cnt and ta_cnt clear; priority pointer ptr goes to 0.
- All outputs are registered and there is no combinational path from req_in.
- States:
  - IDLE: en_out=0. On an edge where req_in!=0: select the first set bit searching ptr, ptr+1, … wrapping modulo N. Grant that index and go to GRANT with hold_cnt=0. Latency: request sampled at edge k, grant visible after edge k.
  - GRANT: en_out/gnt_out one-hot at owner. On each edge:
    - If req_in[owner]=0, release.
    - Else if hold_cnt==MAX_HOLD-1, release.
    - Otherwise hold_cnt+1.
    - The grant is therefore high for at most MAX_HOLD cycles.
  - Release: clear gnt/en at that edge. Set ptr=(owner+1) mod N. Go to TURNAROUND with ta_cnt=0.
  - TURNAROUND: en_out=0 for exactly TA_CYCLES cycles. On the edge where ta_cnt==TA_CYCLES-1:
    - If req_in!=0, arbitrate as in IDLE and go straight to GRANT, so the gap is exactly TA_CYCLES.
    - Else go to IDLE.
    - Otherwise ta_cnt+1.
- Requests that change during TURNAROUND are ignored; only the value at the final turnaround edge counts.
- The released owner keeps lowest priority for the next arbitration. If it is the only requester, it is re-granted after the gap.
- The owner's request dropping and another request rising on the same edge: release takes precedence, and the new requester waits for turnaround.
- owner_out follows the grant; it reads 0 in IDLE and TURNAROUND.
- Invariant: $onehot0(en_out) every cycle. en_out is never nonzero in the cycle immediately after a different nonzero value.
- Reset mid-grant or mid-turnaround: enables drop asynchronously. After deassertion the block restarts from IDLE with ptr=0.

Test Plan:
- Reset hold: rst_n_in=0 with req_in=4'b1111 for 5 clocks -> en_out=0, owner_out=0, busy_out=0. Release reset -> gnt_out=4'b0001 one edge later.
- Single request: req_in=4'b0100 from edge 0, dropped after edge 3 -> en_out=4'b0100 and owner_out=2 for 3 cycles, then 0. Enables stay 0 through TURNAROUND and IDLE.
- Full contention, MAX_HOLD=8, TA_CYCLES=1: req_in=4'b1111 held -> grants 0001, 0010, 0100, 1000, 0001 in order. Each lasts 8 cycles, separated by exactly one all-zero cycle. Assert $onehot0 throughout.
- Lone hog: req_in=4'b0001 constant -> 8 cycles granted, 1 cycle off, re-granted. The pattern repeats with period 9.
- Async reset mid-grant: assert rst_n_in between clock edges while en_out=4'b0010 -> en_out=0 before the next edge. After release with req_in=4'b0011 -> requester 0 is granted first.
- Withdraw in turnaround: req_in=4'b0011. Owner 0 drops its request, and req_in[1] drops during the gap -> block returns to IDLE with no grant. Re-raise req_in[1] -> grant 4'b0010 on the next edge.
